// File: rtl/execute_ldst_queue_port.sv
// execute_ldst_queue_port
//   In-order load/store queue between the scheduler-2 LDST issue slot and the
//   data port. Holds up to DEPTH accepted ops, keeps up to MAX_OUTSTANDING
//   requests in flight, retires completions in program order and, after a
//   synchronous flush, swallows the responses of requests that were already
//   issued.
//
//   Ports
//     iCLOCK, inRESET (async, active-low), iRESET_SYNC (synchronous flush)
//     iPREV_*        : op offered by the scheduler; oPREV_LOCK refuses it
//     oDATAIO_*      : request to the data port, iDATAIO_BUSY stalls it
//     iDATAIO_REQ/_DATA : in-order responses from the data port
//     oSCHE_*        : completion of the oldest in-flight entry
//     oOUTSTANDING   : issued-but-unanswered request count
module execute_ldst_queue_port #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = 32,
  parameter int TAGW            = 6,
  localparam int PW             = $clog2(DEPTH) + 1
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  input  logic            iRESET_SYNC,
  input  logic            iPREV_VALID,
  input  logic            iPREV_RW,
  input  logic [1:0]      iPREV_ORDER,
  input  logic [AW-1:0]   iPREV_ADDR,
  input  logic [31:0]     iPREV_DATA,
  input  logic [TAGW-1:0] iPREV_COMMIT_TAG,
  input  logic [5:0]      iPREV_DEST_REGNAME,
  output logic            oPREV_LOCK,
  output logic            oDATAIO_REQ,
  input  logic            iDATAIO_BUSY,
  output logic            oDATAIO_RW,
  output logic [1:0]      oDATAIO_ORDER,
  output logic [3:0]      oDATAIO_MASK,
  output logic [AW-1:0]   oDATAIO_ADDR,
  output logic [31:0]     oDATAIO_DATA,
  input  logic            iDATAIO_REQ,
  input  logic [31:0]     iDATAIO_DATA,
  output logic            oSCHE_VALID,
  output logic [TAGW-1:0] oSCHE_COMMIT_TAG,
  output logic [5:0]      oSCHE_DESTINATION_REGNAME,
  output logic            oSCHE_WRITEBACK,
  output logic [31:0]     oSCHE_DATA,
  output logic [PW-1:0]   oOUTSTANDING
);

  localparam int IW = PW - 1;

  // Byte offset of the addressed lane group: misaligned half/word ignore the
  // low address bits.
  function automatic logic [1:0] lane_shift(input logic [1:0] ord, input logic [1:0] a);
    case (ord)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_base(input logic [1:0] ord);
    case (ord)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  logic [PW-1:0] wr_q, wr_d, iss_q, iss_d, ret_q, ret_d, drop_q, drop_d;

  logic            rw_q    [DEPTH];
  logic [1:0]      order_q [DEPTH];
  logic [1:0]      shift_q [DEPTH];
  logic [3:0]      mask_q  [DEPTH];
  logic [AW-1:0]   addr_q  [DEPTH];
  logic [31:0]     data_q  [DEPTH];
  logic [TAGW-1:0] tag_q   [DEPTH];
  logic [5:0]      dest_q  [DEPTH];

  logic [PW-1:0] count, inflight, drain_total;
  logic          pending, accept, issue, retire, sche_valid;
  logic [IW-1:0] wr_idx, iss_idx, ret_idx;
  logic [1:0]    acc_shift;
  logic [31:0]   ld_shifted, ld_ext;

  assign count    = wr_q - ret_q;
  assign inflight = iss_q - ret_q;
  assign wr_idx   = wr_q[IW-1:0];
  assign iss_idx  = iss_q[IW-1:0];
  assign ret_idx  = ret_q[IW-1:0];

  assign oPREV_LOCK = (count == PW'(DEPTH)) || (drop_q != '0);
  assign accept     = iPREV_VALID && !oPREV_LOCK;
  assign pending    = (iss_q != wr_q);
  assign issue      = pending && (inflight < PW'(MAX_OUTSTANDING))
                      && !iDATAIO_BUSY && (drop_q == '0);
  assign retire     = iDATAIO_REQ && (inflight != '0) && (drop_q == '0);
  assign sche_valid = retire && !iRESET_SYNC;

  assign acc_shift  = lane_shift(iPREV_ORDER, iPREV_ADDR[1:0]);

  // Requests still owed a response at the flush edge; only one of the two
  // terms can be non-zero since issue is blocked while draining.
  assign drain_total = drop_q + inflight;

  always_comb begin
    wr_d   = wr_q + PW'(accept);
    iss_d  = iss_q + PW'(issue);
    ret_d  = ret_q + PW'(retire);
    drop_d = drop_q;
    if (iRESET_SYNC) begin
      wr_d   = '0;
      iss_d  = '0;
      ret_d  = '0;
      drop_d = drain_total + PW'(issue)
               - PW'(iDATAIO_REQ && (drain_total != '0));
    end else if ((drop_q != '0) && iDATAIO_REQ) begin
      drop_d = drop_q - PW'(1);
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_q   <= '0;
      iss_q  <= '0;
      ret_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      iss_q  <= iss_d;
      ret_q  <= ret_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        rw_q[i]    <= 1'b0;
        order_q[i] <= '0;
        shift_q[i] <= '0;
        mask_q[i]  <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
        dest_q[i]  <= '0;
      end
    end else if (accept) begin
      rw_q[wr_idx]    <= iPREV_RW;
      order_q[wr_idx] <= iPREV_ORDER;
      shift_q[wr_idx] <= acc_shift;
      mask_q[wr_idx]  <= lane_base(iPREV_ORDER) << acc_shift;
      addr_q[wr_idx]  <= iPREV_ADDR;
      data_q[wr_idx]  <= iPREV_DATA << {acc_shift, 3'b000};
      tag_q[wr_idx]   <= iPREV_COMMIT_TAG;
      dest_q[wr_idx]  <= iPREV_DEST_REGNAME;
    end
  end

  assign oDATAIO_REQ   = issue;
  assign oDATAIO_RW    = pending ? rw_q[iss_idx]    : 1'b0;
  assign oDATAIO_ORDER = pending ? order_q[iss_idx] : 2'b00;
  assign oDATAIO_MASK  = pending ? mask_q[iss_idx]  : 4'b0000;
  assign oDATAIO_ADDR  = pending ? addr_q[iss_idx]  : '0;
  assign oDATAIO_DATA  = pending ? data_q[iss_idx]  : 32'h0;

  assign ld_shifted = iDATAIO_DATA >> {shift_q[ret_idx], 3'b000};
  always_comb begin
    case (order_q[ret_idx])
      2'b00:   ld_ext = ld_shifted & 32'h0000_00FF;
      2'b01:   ld_ext = ld_shifted & 32'h0000_FFFF;
      default: ld_ext = ld_shifted;
    endcase
  end

  assign oSCHE_VALID               = sche_valid;
  assign oSCHE_COMMIT_TAG          = sche_valid ? tag_q[ret_idx] : '0;
  assign oSCHE_DESTINATION_REGNAME = sche_valid ? dest_q[ret_idx] : 6'd0;
  assign oSCHE_WRITEBACK           = sche_valid && !rw_q[ret_idx];
  assign oSCHE_DATA                = (sche_valid && !rw_q[ret_idx]) ? ld_ext : 32'h0;
  assign oOUTSTANDING              = inflight;

endmodule

// File: tb/tb_execute_ldst_queue_port.sv
// Testbench for execute_ldst_queue_port (DEPTH=4, MAX_OUTSTANDING=2).
module tb_execute_ldst_queue_port;

  logic        iCLOCK, inRESET, iRESET_SYNC;
  logic        iPREV_VALID, iPREV_RW;
  logic [1:0]  iPREV_ORDER;
  logic [31:0] iPREV_ADDR, iPREV_DATA;
  logic [5:0]  iPREV_COMMIT_TAG, iPREV_DEST_REGNAME;
  logic        oPREV_LOCK, oDATAIO_REQ, iDATAIO_BUSY, oDATAIO_RW;
  logic [1:0]  oDATAIO_ORDER;
  logic [3:0]  oDATAIO_MASK;
  logic [31:0] oDATAIO_ADDR, oDATAIO_DATA;
  logic        iDATAIO_REQ;
  logic [31:0] iDATAIO_DATA;
  logic        oSCHE_VALID;
  logic [5:0]  oSCHE_COMMIT_TAG, oSCHE_DESTINATION_REGNAME;
  logic        oSCHE_WRITEBACK;
  logic [31:0] oSCHE_DATA;
  logic [2:0]  oOUTSTANDING;

  int total = 0;
  int bad   = 0;

  execute_ldst_queue_port #(.DEPTH(4), .MAX_OUTSTANDING(2), .AW(32), .TAGW(6)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPREV_VALID(iPREV_VALID), .iPREV_RW(iPREV_RW), .iPREV_ORDER(iPREV_ORDER),
    .iPREV_ADDR(iPREV_ADDR), .iPREV_DATA(iPREV_DATA),
    .iPREV_COMMIT_TAG(iPREV_COMMIT_TAG), .iPREV_DEST_REGNAME(iPREV_DEST_REGNAME),
    .oPREV_LOCK(oPREV_LOCK), .oDATAIO_REQ(oDATAIO_REQ), .iDATAIO_BUSY(iDATAIO_BUSY),
    .oDATAIO_RW(oDATAIO_RW), .oDATAIO_ORDER(oDATAIO_ORDER), .oDATAIO_MASK(oDATAIO_MASK),
    .oDATAIO_ADDR(oDATAIO_ADDR), .oDATAIO_DATA(oDATAIO_DATA),
    .iDATAIO_REQ(iDATAIO_REQ), .iDATAIO_DATA(iDATAIO_DATA),
    .oSCHE_VALID(oSCHE_VALID), .oSCHE_COMMIT_TAG(oSCHE_COMMIT_TAG),
    .oSCHE_DESTINATION_REGNAME(oSCHE_DESTINATION_REGNAME),
    .oSCHE_WRITEBACK(oSCHE_WRITEBACK), .oSCHE_DATA(oSCHE_DATA),
    .oOUTSTANDING(oOUTSTANDING)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic offer(input logic v, input logic rw, input logic [1:0] ord,
                       input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
    iPREV_VALID = v; iPREV_RW = rw; iPREV_ORDER = ord;
    iPREV_ADDR = a; iPREV_DATA = d; iPREV_COMMIT_TAG = t; iPREV_DEST_REGNAME = t;
  endtask

  typedef struct {
    logic        valid;
    logic        rw;
    logic [1:0]  order;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  tag;
    logic        resp;
    logic [31:0] rdata;
    logic        e_lock;
    logic        e_req;
    logic        e_drw;
    logic [3:0]  e_mask;
    logic [31:0] e_daddr;
    logic [31:0] e_ddata;
    logic        e_sv;
    logic        e_wb;
    logic [5:0]  e_stag;
    logic [31:0] e_sdata;
    logic [2:0]  e_out;
  } vec_t;

  vec_t vec[20];

  int acc, iss_n, ret_n, cyc;
  int rq[$];
  logic rsp, e_lock, e_req;

  initial begin
    // valid rw ord addr data tag | resp rdata | lock req drw mask daddr ddata | sv wb stag sdata out
    vec[0]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[1]  = '{1,0,2'd0,32'h1003,32'h0,6'd5,      0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[2]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,0,4'h8,32'h1003,32'h0,          0,0,6'd0,32'h0,3'd0};
    vec[3]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'hAABBCCDD, 0,0,0,4'h0,32'h0,32'h0,             1,1,6'd5,32'hAA,3'd1};
    vec[4]  = '{1,1,2'd1,32'h2002,32'h1234,6'd6,   0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[5]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,1,4'hC,32'h2002,32'h12340000,   0,0,6'd0,32'h0,3'd0};
    vec[6]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'hFFFFFFFF, 0,0,0,4'h0,32'h0,32'h0,             1,0,6'd6,32'h0,3'd1};
    vec[7]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'h12345678, 0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[8]  = '{1,0,2'd1,32'h3001,32'h0,6'd7,      0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[9]  = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,0,4'h3,32'h3001,32'h0,          0,0,6'd0,32'h0,3'd0};
    vec[10] = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'h87654321, 0,0,0,4'h0,32'h0,32'h0,             1,1,6'd7,32'h4321,3'd1};
    vec[11] = '{1,1,2'd0,32'h0002,32'hAB,6'd8,     0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[12] = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,1,4'h4,32'h0002,32'h00AB0000,   0,0,6'd0,32'h0,3'd0};
    vec[13] = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'h0,        0,0,0,4'h0,32'h0,32'h0,             1,0,6'd8,32'h0,3'd1};
    vec[14] = '{1,0,2'd3,32'h0013,32'h0,6'd9,      0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[15] = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,0,4'hF,32'h0013,32'h0,          0,0,6'd0,32'h0,3'd0};
    vec[16] = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'hDEADBEEF, 0,0,0,4'h0,32'h0,32'h0,             1,1,6'd9,32'hDEADBEEF,3'd1};
    vec[17] = '{1,0,2'd1,32'h0006,32'h0,6'd10,     0,32'h0,        0,0,0,4'h0,32'h0,32'h0,             0,0,6'd0,32'h0,3'd0};
    vec[18] = '{0,0,2'd0,32'h0,32'h0,6'd0,         0,32'h0,        0,1,0,4'hC,32'h0006,32'h0,          0,0,6'd0,32'h0,3'd0};
    vec[19] = '{0,0,2'd0,32'h0,32'h0,6'd0,         1,32'hA1B2C3D4, 0,0,0,4'h0,32'h0,32'h0,             1,1,6'd10,32'hA1B2,3'd1};

    inRESET = 1'b0; iRESET_SYNC = 1'b0; iDATAIO_BUSY = 1'b0;
    iDATAIO_REQ = 1'b0; iDATAIO_DATA = 32'h0;
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    #2;
    chk("rst_lock", 32'(oPREV_LOCK), 0);
    chk("rst_req", 32'(oDATAIO_REQ), 0);
    chk("rst_out", 32'(oOUTSTANDING), 0);
    chk("rst_sv", 32'(oSCHE_VALID), 0);
    step(); step();
    inRESET = 1'b1;
    step();

    // table-driven single-op vectors
    for (int i = 0; i < 20; i++) begin
      offer(vec[i].valid, vec[i].rw, vec[i].order, vec[i].addr, vec[i].data, vec[i].tag);
      iDATAIO_REQ = vec[i].resp; iDATAIO_DATA = vec[i].rdata;
      #1;
      chk($sformatf("v%0d_lock", i), 32'(oPREV_LOCK), 32'(vec[i].e_lock));
      chk($sformatf("v%0d_req", i), 32'(oDATAIO_REQ), 32'(vec[i].e_req));
      chk($sformatf("v%0d_drw", i), 32'(oDATAIO_RW), 32'(vec[i].e_drw));
      chk($sformatf("v%0d_mask", i), 32'(oDATAIO_MASK), 32'(vec[i].e_mask));
      chk($sformatf("v%0d_daddr", i), oDATAIO_ADDR, vec[i].e_daddr);
      chk($sformatf("v%0d_ddata", i), oDATAIO_DATA, vec[i].e_ddata);
      chk($sformatf("v%0d_sv", i), 32'(oSCHE_VALID), 32'(vec[i].e_sv));
      chk($sformatf("v%0d_wb", i), 32'(oSCHE_WRITEBACK), 32'(vec[i].e_wb));
      chk($sformatf("v%0d_stag", i), 32'(oSCHE_COMMIT_TAG), 32'(vec[i].e_stag));
      chk($sformatf("v%0d_sdest", i), 32'(oSCHE_DESTINATION_REGNAME), 32'(vec[i].e_stag));
      chk($sformatf("v%0d_sdata", i), oSCHE_DATA, vec[i].e_sdata);
      chk($sformatf("v%0d_out", i), 32'(oOUTSTANDING), 32'(vec[i].e_out));
      step();
    end
    iDATAIO_REQ = 1'b0;
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);

    // six back-to-back word loads, responses 5 cycles after issue
    acc = 0; iss_n = 0; ret_n = 0; cyc = 0;
    while (ret_n < 6 && cyc < 200) begin
      offer(acc < 6, 0, 2'd2, 32'(acc * 4), 32'h0, 6'(acc));
      rsp = (rq.size() > 0) && (cyc >= rq[0]);
      iDATAIO_REQ = rsp; iDATAIO_DATA = 32'(ret_n + 32'h100);
      #1;
      e_lock = ((acc - ret_n) == 4);
      e_req  = (iss_n < acc) && ((iss_n - ret_n) < 2);
      chk("q_lock", 32'(oPREV_LOCK), 32'(e_lock));
      chk("q_req", 32'(oDATAIO_REQ), 32'(e_req));
      chk("q_out", 32'(oOUTSTANDING), 32'(iss_n - ret_n));
      chk("q_sv", 32'(oSCHE_VALID), 32'(rsp));
      if (rsp) begin
        chk("q_tag", 32'(oSCHE_COMMIT_TAG), 32'(ret_n));
        chk("q_data", oSCHE_DATA, 32'(ret_n + 32'h100));
      end
      if (iPREV_VALID && !e_lock) acc++;
      if (e_req) begin iss_n++; rq.push_back(cyc + 5); end
      if (rsp) begin ret_n++; void'(rq.pop_front()); end
      step();
      cyc++;
    end
    iDATAIO_REQ = 1'b0;
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    #1;
    chk("q_out_end", 32'(oOUTSTANDING), 0);
    chk("q_lock_end", 32'(oPREV_LOCK), 0);
    step();

    // BUSY held three cycles with one queued store
    offer(1, 1, 2'd2, 32'h40, 32'hCAFEF00D, 6'd11);
    step();
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    iDATAIO_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_req", 32'(oDATAIO_REQ), 0);
      chk("busy_out", 32'(oOUTSTANDING), 0);
      step();
    end
    iDATAIO_BUSY = 1'b0;
    #1;
    chk("busy_rel_req", 32'(oDATAIO_REQ), 1);
    chk("busy_rel_addr", oDATAIO_ADDR, 32'h40);
    chk("busy_rel_ord", 32'(oDATAIO_ORDER), 2);
    chk("busy_rel_data", oDATAIO_DATA, 32'hCAFEF00D);
    step();
    #1;
    chk("busy_once_req", 32'(oDATAIO_REQ), 0);
    chk("busy_once_out", 32'(oOUTSTANDING), 1);
    iDATAIO_REQ = 1'b1;
    #1;
    chk("busy_cpl_sv", 32'(oSCHE_VALID), 1);
    chk("busy_cpl_tag", 32'(oSCHE_COMMIT_TAG), 11);
    chk("busy_cpl_wb", 32'(oSCHE_WRITEBACK), 0);
    step();
    iDATAIO_REQ = 1'b0;

    // flush with two in flight and one queued
    offer(1, 0, 2'd2, 32'h100, 32'h0, 6'd20);
    #1; chk("fl_c0_req", 32'(oDATAIO_REQ), 0);
    step();
    offer(1, 0, 2'd2, 32'h104, 32'h0, 6'd21);
    #1; chk("fl_c1_req", 32'(oDATAIO_REQ), 1);
    step();
    offer(1, 0, 2'd2, 32'h108, 32'h0, 6'd22);
    #1; chk("fl_c2_req", 32'(oDATAIO_REQ), 1);
    step();
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    #1;
    chk("fl_c3_req", 32'(oDATAIO_REQ), 0);
    chk("fl_c3_out", 32'(oOUTSTANDING), 2);
    iRESET_SYNC = 1'b1;
    #1; chk("fl_sv", 32'(oSCHE_VALID), 0);
    step();
    iRESET_SYNC = 1'b0;
    offer(1, 0, 2'd2, 32'h200, 32'h0, 6'd25);
    #1;
    chk("fl_lock0", 32'(oPREV_LOCK), 1);
    chk("fl_req0", 32'(oDATAIO_REQ), 0);
    chk("fl_out0", 32'(oOUTSTANDING), 0);
    step();
    for (int i = 0; i < 2; i++) begin
      iDATAIO_REQ = 1'b1; iDATAIO_DATA = 32'h11111111;
      #1;
      chk("fl_drop_sv", 32'(oSCHE_VALID), 0);
      chk("fl_drop_lock", 32'(oPREV_LOCK), 1);
      step();
    end
    iDATAIO_REQ = 1'b0;
    offer(1, 0, 2'd0, 32'h1001, 32'h0, 6'd30);
    #1;
    chk("fl_unlock", 32'(oPREV_LOCK), 0);
    chk("fl_empty_req", 32'(oDATAIO_REQ), 0);
    chk("fl_empty_out", 32'(oOUTSTANDING), 0);
    step();
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    #1;
    chk("fl_new_req", 32'(oDATAIO_REQ), 1);
    chk("fl_new_mask", 32'(oDATAIO_MASK), 4'h2);
    chk("fl_new_addr", oDATAIO_ADDR, 32'h1001);
    step();
    iDATAIO_REQ = 1'b1; iDATAIO_DATA = 32'h00005500;
    #1;
    chk("fl_new_sv", 32'(oSCHE_VALID), 1);
    chk("fl_new_tag", 32'(oSCHE_COMMIT_TAG), 30);
    chk("fl_new_data", oSCHE_DATA, 32'h55);
    step();
    iDATAIO_REQ = 1'b0;

    // async reset mid-transfer
    offer(1, 0, 2'd2, 32'h300, 32'h0, 6'd40);
    step();
    offer(0, 0, 2'd0, 32'h0, 32'h0, 6'd0);
    #1; chk("ar_req", 32'(oDATAIO_REQ), 1);
    step();
    iDATAIO_REQ = 1'b1; iDATAIO_DATA = 32'h12345678;
    #1; chk("ar_pre_sv", 32'(oSCHE_VALID), 1);
    inRESET = 1'b0;
    #1;
    chk("ar_sv", 32'(oSCHE_VALID), 0);
    chk("ar_sdata", oSCHE_DATA, 0);
    chk("ar_req0", 32'(oDATAIO_REQ), 0);
    chk("ar_addr", oDATAIO_ADDR, 0);
    chk("ar_lock", 32'(oPREV_LOCK), 0);
    chk("ar_out", 32'(oOUTSTANDING), 0);
    #1;
    inRESET = 1'b1;
    #1;
    chk("ar_post_sv", 32'(oSCHE_VALID), 0);
    step();
    iDATAIO_REQ = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
